// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: MEM/WB pipeline versus a 2-entry multi-cycle result FIFO.
// Define WB_STARVE_EN to add the starvation counter and RUN/STALL FSM that forces a FIFO drain.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mc_req,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ack,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gen_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic [4:0]  fifo_addr_q [2];
    logic [4:0]  fifo_addr_d [2];
    logic [31:0] fifo_data_q [2];
    logic [31:0] fifo_data_d [2];
    logic [1:0]  count_q, count_d;
    logic [1:0]  count_c;
    logic        keep0, keep1;
    logic        stall, grant_pipe, grant_fifo;

    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    // Acceptance looks only at the current count; a same-cycle pop does not free a slot.
    assign mc_ack     = rst & mc_req & (count_q != 2'd2);
    assign grant_fifo = (count_q != 2'd0) & (stall | ~wb_we);
    assign grant_pipe = ~stall & wb_we;

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        keep0 = (count_q != 2'd0) & ~grant_fifo & ~(grant_pipe & (fifo_addr_q[0] == wb_addr));
        keep1 = (count_q == 2'd2) & ~(grant_pipe & (fifo_addr_q[1] == wb_addr));
        if (!keep0 && keep1) begin
            fifo_addr_d[0] = fifo_addr_q[1];
            fifo_data_d[0] = fifo_data_q[1];
        end
        count_c = {1'b0, keep0} + {1'b0, keep1};
        // A push implies count_q < 2, so the compacted count is 0 or 1 here.
        if (mc_ack) begin
            fifo_addr_d[count_c[0]] = mc_addr;
            fifo_data_d[count_c[0]] = mc_data;
        end
        count_d = count_c + {1'b0, mc_ack};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= 5'd0;
                fifo_data_q[i] <= 32'h0;
            end
        end else begin
            count_q     <= count_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'h0;
        end else begin
            rf_we_q <= grant_pipe | grant_fifo;
            if (grant_pipe) begin
                rf_waddr_q <= wb_addr;
                rf_wdata_q <= wb_data;
            end else if (grant_fifo) begin
                rf_waddr_q <= fifo_addr_q[0];
                rf_wdata_q <= fifo_data_q[0];
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_STARVE_EN
    typedef enum logic {StRun, StStall} state_e;

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    // Starvation counts only while an entry survives compaction, so a FIFO emptied by
    // invalidation never triggers a stall.
    always_comb begin
        state_d  = state_q;
        starve_d = 4'd0;
        unique case (state_q)
            StRun: begin
                if (grant_pipe && count_c != 2'd0) begin
                    starve_d = (starve_q < Limit) ? starve_q + 4'd1 : starve_q;
                    if (starve_d == Limit) begin
                        state_d = StStall;
                    end
                end
            end
            StStall: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign stall = (state_q == StStall);
`else
    assign stall = 1'b0;
`endif

    assign pipe_stall = stall;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL provide parameter: STARVE_LIMIT, 4, consecutive blocked cycles before the FIFO head is forced onto the write port (legal range 1..15).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL provide port: rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port: wb_we  input  1  pipeline writeback valid, driven by the MEM/WB stage.
REQ-005 SHALL provide port: wb_addr  input  5  pipeline destination register.
REQ-006 SHALL provide port: wb_data  input  32  pipeline writeback data.
REQ-007 SHALL provide port: mc_req  input  1  multi-cycle unit result valid.
REQ-008 SHALL provide port: mc_addr  input  5  multi-cycle destination register.
REQ-009 SHALL provide port: mc_data  input  32  multi-cycle result data.
REQ-010 SHALL provide port: mc_ack  output  1  combinational; result accepted this cycle.
REQ-011 SHALL provide port: rf_we  output  1  registered register-file write enable.
REQ-012 SHALL provide port: rf_waddr  output  5  registered write address.
REQ-013 SHALL provide port: rf_wdata  output  32  registered write data.
REQ-014 SHALL provide port: pipe_stall  output  1  registered; hold the MEM/WB stage.

Function
REQ-015 SHALL buffer multi-cycle results in a 2-entry in-order FIFO with count 0..2.
REQ-016 SHALL drive mc_ack = mc_req AND count<2, so a full FIFO refuses the result even when a pop occurs in the same cycle.
REQ-017 SHALL grant the write port each cycle as follows: if pipe_stall=1, the FIFO head; else if wb_we=1, the pipeline; else if count>0, the FIFO head; else no write.
REQ-018 SHALL register the granted address and data onto rf_waddr/rf_wdata with rf_we=1 one cycle after the grant (latency 1), and SHALL drive rf_we=0 when there is no grant.
REQ-019 SHALL ignore wb_we while pipe_stall=1; the pipeline re-presents the same write on the following cycle.
REQ-020 SHALL, when the pipeline is granted and wb_addr equals the address of any FIFO entry, invalidate those entries (the younger pipeline write wins), compacting the FIFO in the same cycle.
REQ-021 SHALL, when the FIFO is empty and mc_req=1 with no pipeline grant, accept the result and pop it only on the following cycle; there is no same-cycle bypass.
REQ-022 SHALL keep starve_cnt at 0..STARVE_LIMIT: increment it on each cycle with count>0 and a pipeline grant, and clear it on any FIFO pop or when count=0.
REQ-023 SHALL implement a 2-state FSM: RUN to STALL when starve_cnt reaches STARVE_LIMIT (pipe_stall=1 on the next cycle); STALL to RUN after exactly one cycle, clearing starve_cnt.
REQ-024 SHALL, when a FIFO entry is invalidated by REQ-020 in the same cycle that RUN would enter STALL, enter STALL only if count>0 after compaction.

Reset
REQ-025 SHALL, while rst=0, force rf_we=0, rf_waddr=0, rf_wdata=32'h0, pipe_stall=0, mc_ack=0, count=0, starve_cnt=0 and FSM=RUN, independent of clk.
REQ-026 SHALL discard FIFO contents when reset asserts mid-operation, and SHALL perform no write on the first edge after release.

Configuration
REQ-027 SHALL, with WB_STARVE_EN defined, implement REQ-022 to REQ-024.
REQ-028 SHALL, without WB_STARVE_EN, remove starve_cnt and the FSM, tie pipe_stall to 0, and drain the FIFO only in cycles with wb_we=0.

Verification
REQ-029 SHALL cover: wb_we=1, addr 3, data 0xA5A5_0001 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xA5A5_0001.
REQ-030 SHALL cover: two mc results accepted, third mc_req=1 while wb_we=1 continuously -> mc_ack=0 on the third request; count stays 2.
REQ-031 SHALL cover: WB_STARVE_EN, count=1, wb_we held 1 for 4 cycles -> pipe_stall=1 on cycle 5, FIFO head written on cycle 6, pipeline write resumes on cycle 7.
REQ-032 SHALL cover: FIFO holds addr 7, pipeline writes addr 7 data 0x11 -> only 0x11 is written to r7; count returns to 0.
REQ-033 SHALL cover: rst driven to 0 mid-stall with count=2 -> all outputs 0 immediately; after release, no write until a new request arrives.
REQ-034 SHALL cover: without WB_STARVE_EN, wb_we held 1 for 20 cycles with count=1 -> pipe_stall stays 0; FIFO drains in the first cycle with wb_we=0.
